// File: rtl/spi_ram_pkg.sv
// Shared constants and FSM encoding for the host-side SPI RAM link.
package spi_ram_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned RX_BITS    = 8;

   typedef enum logic [2:0] {
      StIdle,
      StTx1,
      StGap,
      StTx2,
      StTurn,
      StRx,
      StDone
   } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled, phase reset when disabled.
// rise/fall strobe in the cycle whose closing edge moves sclk.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic [DivW-1:0] cnt_q;
   logic            sclk_q;
   logic            tick;

   assign tick = en && (cnt_q == DivLast);
   assign rise = tick && !sclk_q;
   assign fall = tick && sclk_q;
   assign sclk = sclk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else if (!en) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else if (tick) begin
         cnt_q  <= '0;
         sclk_q <= ~sclk_q;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: turns single read/write requests into two command frames
// on MOSI and, for reads, collects the RAM word from MISO.
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned ADDR_SIZE   = 8,
   parameter int unsigned TURN_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [ADDR_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_data,
   output logic                 sclk,
   output logic                 ss_n,
   output logic                 mosi,
   input  logic                 miso
);

   localparam int unsigned FrameW = ADDR_SIZE + (FRAME_BITS - RX_BITS);
   localparam logic [7:0]  TxLast   = 8'(FrameW - 1);
   localparam logic [7:0]  RxLast   = 8'(ADDR_SIZE - 1);
   localparam logic [7:0]  TurnLast = 8'(TURN_CYCLES - 1);
   // GAP holds 2N-1 cycles; the frame-start cycle in TX2 completes the 2N-cycle gap.
   localparam logic [15:0] GapLast  = 16'(2 * CLK_DIV - 2);

   state_e                 state_q;
   logic                   write_q;
   logic [ADDR_SIZE-1:0]   wdata_q;
   logic [FrameW-1:0]      tx_sr_q;
   logic [ADDR_SIZE-1:0]   rx_sr_q;
   logic [7:0]             bit_q;
   logic [15:0]            gap_q;
   logic                   ss_n_q;
   logic                   mosi_q;
   logic                   ready_q;
   logic                   rsp_valid_q;
   logic [ADDR_SIZE-1:0]   rsp_data_q;
   logic                   sclk_rise;
   logic                   sclk_fall;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (!ss_n_q),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign ss_n      = ss_n_q;
   assign mosi      = mosi_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         bit_q       <= '0;
         gap_q       <= '0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  write_q <= req_write;
                  wdata_q <= req_wdata;
                  tx_sr_q <= {(req_write ? CMD_WR_ADDR : CMD_RD_ADDR), req_addr};
                  state_q <= StTx1;
               end
            end
            StTx1, StTx2: begin
               if (ss_n_q) begin
                  // First cycle of a frame: drop select, present the MSB.
                  ss_n_q <= 1'b0;
                  mosi_q <= tx_sr_q[FrameW-1];
                  bit_q  <= '0;
               end else if (sclk_fall) begin
                  if (bit_q == TxLast) begin
                     bit_q  <= '0;
                     mosi_q <= 1'b0;
                     if (state_q == StTx1) begin
                        ss_n_q  <= 1'b1;
                        gap_q   <= '0;
                        tx_sr_q <= {(write_q ? CMD_WR_DATA : CMD_RD_DATA),
                                    (write_q ? wdata_q : {ADDR_SIZE{1'b0}})};
                        state_q <= StGap;
                     end else if (write_q) begin
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= StDone;
                     end else begin
                        state_q <= (TURN_CYCLES == 0) ? StRx : StTurn;
                     end
                  end else begin
                     bit_q   <= bit_q + 8'd1;
                     tx_sr_q <= tx_sr_q << 1;
                     mosi_q  <= tx_sr_q[FrameW-2];
                  end
               end
            end
            StGap: begin
               if (gap_q == GapLast) begin
                  state_q <= StTx2;
               end else begin
                  gap_q <= gap_q + 16'd1;
               end
            end
            StTurn: begin
               if (sclk_fall) begin
                  if (bit_q == TurnLast) begin
                     bit_q   <= '0;
                     state_q <= StRx;
                  end else begin
                     bit_q <= bit_q + 8'd1;
                  end
               end
            end
            StRx: begin
               if (sclk_rise) begin
                  rx_sr_q <= {rx_sr_q[ADDR_SIZE-2:0], miso};
               end
               if (sclk_fall) begin
                  if (bit_q == RxLast) begin
                     ss_n_q      <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= rx_sr_q;
                     state_q     <= StDone;
                  end else begin
                     bit_q <= bit_q + 8'd1;
                  end
               end
            end
            StDone: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each with a small SPI slave model that records MOSI frames and serves MISO.
module tb_spi_ram_master;

   logic       clk = 1'b0;
   logic       rst;

   logic       req_valid, req_ready, req_write, rsp_valid, sclk, ss_n, mosi, miso;
   logic [7:0] req_addr, req_wdata, rsp_data;
   logic       req1_valid, req1_ready, req1_write, rsp1_valid, sclk1, ss1_n, mosi1, miso1;
   logic [7:0] req1_addr, req1_wdata, rsp1_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_ram_master #(.CLK_DIV(2), .ADDR_SIZE(8), .TURN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sclk(sclk), .ss_n(ss_n),
      .mosi(mosi), .miso(miso)
   );

   spi_ram_master #(.CLK_DIV(1), .ADDR_SIZE(8), .TURN_CYCLES(2)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req1_valid), .req_ready(req1_ready),
      .req_write(req1_write), .req_addr(req1_addr), .req_wdata(req1_wdata),
      .rsp_valid(rsp1_valid), .rsp_data(rsp1_data), .sclk(sclk1), .ss_n(ss1_n),
      .mosi(mosi1), .miso(miso1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Slave models: rising-edge MOSI capture (first 10 bits per select), MISO on falling edges.
   int         rc = 0, rc1 = 0, nfr = 0;
   logic [9:0] fsh, fsh1;
   logic [9:0] frm [0:7];
   logic [7:0] rd_val = 8'h00, rd_val1 = 8'h00;

   initial begin
      miso  = 1'b0;
      miso1 = 1'b0;
   end

   always @(negedge ss_n) begin rc = 0; fsh = '0; end
   always @(posedge sclk) if (!ss_n) begin
      if (rc < 10) fsh = {fsh[8:0], mosi};
      rc++;
   end
   always @(posedge ss_n) begin
      if (nfr < 8) frm[nfr] = fsh;
      nfr++;
   end
   always @(negedge sclk) miso = (rc >= 12 && rc < 20) ? rd_val[19-rc] : 1'b0;

   always @(negedge ss1_n) begin rc1 = 0; fsh1 = '0; end
   always @(posedge sclk1) if (!ss1_n) begin
      if (rc1 < 10) fsh1 = {fsh1[8:0], mosi1};
      rc1++;
   end
   always @(negedge sclk1) miso1 = (rc1 >= 12 && rc1 < 20) ? rd_val1[19-rc1] : 1'b0;

   // Negedge monitor: cycle stamps of acceptance edges and response pulses.
   int         cyc = 0, n_acc = 0, n_rsp = 0, n_acc1 = 0, n_rsp1 = 0;
   int         acc_cyc [0:31], rsp_cyc [0:31], acc1_cyc [0:31], rsp1_cyc [0:31];
   logic [7:0] rsp_dat [0:31], rsp1_dat [0:31];
   int         rise_at = 0, gap_len = 0, rdy_busy = 0, viol_hi = 0, stay1 = 0, tog1 = 0;
   logic       busy = 1'b0, ss_prev = 1'b1, ss1_prev = 1'b1, sclk1_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) busy = 1'b0;
      if (busy && req_ready) rdy_busy++;
      if ((ss_n && sclk) || (ss1_n && sclk1)) viol_hi++;
      if (ss_n && !ss_prev) rise_at = cyc;
      if (!ss_n && ss_prev) gap_len = cyc - rise_at;
      ss_prev = ss_n;
      if (rsp_valid && n_rsp < 32) begin
         rsp_cyc[n_rsp] = cyc; rsp_dat[n_rsp] = rsp_data; n_rsp++; busy = 1'b0;
      end
      if (req_valid && req_ready && !rst && n_acc < 32) begin
         acc_cyc[n_acc] = cyc + 1; n_acc++; busy = 1'b1;
      end
      if (!ss1_n && !ss1_prev) begin
         if (sclk1 == sclk1_prev) stay1++; else tog1++;
      end
      ss1_prev = ss1_n; sclk1_prev = sclk1;
      if (rsp1_valid && n_rsp1 < 32) begin
         rsp1_cyc[n_rsp1] = cyc; rsp1_dat[n_rsp1] = rsp1_data; n_rsp1++;
      end
      if (req1_valid && req1_ready && !rst && n_acc1 < 32) begin
         acc1_cyc[n_acc1] = cyc + 1; n_acc1++;
      end
   end

   // Present one request, hold it until accepted, then scramble the fields.
   task automatic issue(input int which, input logic w, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      logic rdy;
      @(posedge clk); #1;
      if (which == 0) begin req_valid = 1; req_write = w; req_addr = a; req_wdata = d; end
      else begin req1_valid = 1; req1_write = w; req1_addr = a; req1_wdata = d; end
      @(negedge clk);
      rdy = (which == 0) ? req_ready : req1_ready;
      while (!rdy && n < 1000) begin
         @(negedge clk); n++;
         rdy = (which == 0) ? req_ready : req1_ready;
      end
      chk("issue_ready", rdy, 1);
      @(posedge clk); #1;
      if (which == 0) begin req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~d; end
      else begin req1_valid = 0; req1_write = ~w; req1_addr = ~a; req1_wdata = ~d; end
   endtask

   task automatic wait_rsp(input int which, input int target, input string tag);
      int n = 0;
      while (((which == 0) ? n_rsp : n_rsp1) < target && n < 2000) begin
         @(negedge clk); n++;
      end
      chk(tag, (((which == 0) ? n_rsp : n_rsp1) >= target), 1);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ka, kr, viol, n;
      rst = 1'b1;
      req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
      req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", ss_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);

      viol = 0;
      repeat (200) begin
         @(negedge clk);
         if (sclk !== 1'b0 || ss_n !== 1'b1 || rsp_valid !== 1'b0 ||
             sclk1 !== 1'b0 || ss1_n !== 1'b1 || rsp1_valid !== 1'b0) viol++;
      end
      chk("idle_bus", viol, 0);

      // Write 0x3C <- 0xA5; fields are scrambled right after acceptance.
      nfr = 0; ka = n_acc; kr = n_rsp;
      issue(0, 1'b1, 8'h3C, 8'hA5);
      wait_rsp(0, kr + 1, "wr_done");
      chk("wr_nframes", nfr, 2);
      chk("wr_frame0", frm[0], 10'b00_00111100);
      chk("wr_frame1", frm[1], 10'b01_10100101);
      chk("wr_gap", gap_len, 4);
      chk("wr_latency", rsp_cyc[kr] - acc_cyc[ka], 85);
      chk("wr_rsp_data", rsp_dat[kr], 8'h00);

      // Read 0x3C, slave returns 0xA5.
      nfr = 0; rd_val = 8'hA5; ka = n_acc; kr = n_rsp;
      issue(0, 1'b0, 8'h3C, 8'h99);
      wait_rsp(0, kr + 1, "rd_done");
      chk("rd_frame0", frm[0], 10'b10_00111100);
      chk("rd_frame1", frm[1], 10'b11_00000000);
      chk("rd_latency", rsp_cyc[kr] - acc_cyc[ka], 125);
      chk("rd_rsp_data", rsp_dat[kr], 8'hA5);
      repeat (10) @(negedge clk);
      chk("rd_hold", rsp_data, 8'hA5);

      // Back-to-back: valid held high, write then read queued.
      rd_val = 8'hC3; ka = n_acc; kr = n_rsp; rdy_busy = 0;
      @(posedge clk); #1;
      req_valid = 1; req_write = 1; req_addr = 8'h11; req_wdata = 8'h22;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 1000);
      @(posedge clk); #1;
      req_write = 0; req_addr = 8'h44; req_wdata = 8'h00;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 1000);
      @(posedge clk); #1;
      req_valid = 0;
      wait_rsp(0, kr + 2, "b2b_done");
      chk("b2b_accept_gap", acc_cyc[ka+1] - rsp_cyc[kr], 2);
      chk("b2b_ready_low", rdy_busy, 0);
      chk("b2b_wr_data", rsp_dat[kr], 8'h00);
      chk("b2b_rd_data", rsp_dat[kr+1], 8'hC3);

      // Reset while sclk is high in the middle of the second frame of a read.
      nfr = 0; rd_val = 8'h77; kr = n_rsp;
      issue(0, 1'b0, 8'h10, 8'h00);
      n = 0;
      while (!(nfr == 1 && !ss_n && rc >= 5 && sclk) && n < 1000) begin
         @(negedge clk); n++;
      end
      chk("mid_reached", (nfr == 1 && !ss_n && sclk), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ss_n", ss_n, 1);
      chk("mid_rst_sclk", sclk, 0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_rsp", n_rsp, kr);

      nfr = 0; ka = n_acc; kr = n_rsp;
      issue(0, 1'b0, 8'h00, 8'h00);
      wait_rsp(0, kr + 1, "post_rst_done");
      chk("post_rst_frame0", frm[0], 10'b10_00000000);
      chk("post_rst_latency", rsp_cyc[kr] - acc_cyc[ka], 125);
      chk("post_rst_data", rsp_dat[kr], 8'h77);

      // CLK_DIV=1 instance: read returning 0x5A.
      rd_val1 = 8'h5A; ka = n_acc1; kr = n_rsp1; stay1 = 0; tog1 = 0;
      issue(1, 1'b0, 8'h3C, 8'h00);
      wait_rsp(1, kr + 1, "cd1_done");
      chk("cd1_latency", rsp1_cyc[kr] - acc1_cyc[ka], 63);
      chk("cd1_data", rsp1_dat[kr], 8'h5A);
      chk("cd1_stalls", stay1, 0);
      chk("cd1_toggles", tog1, 58);

      chk("sclk_while_deselected", viol_hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
